// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiply and
// restoring divide, one bit per cycle, with a pipeline stall request while running.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            stall_req
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc_q, acc_d;       // product accumulator, or dividend/quotient shifter in [XLEN-1:0]
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        rd_q, rd_d;

   // Operand decode at accept
   logic            is_div_in;
   logic            a_signed, b_signed;
   logic            sign_a, sign_b;
   logic            neg_in;
   logic            div_zero, div_ovf, fast_in;
   logic [XLEN-1:0] abs_a, abs_b, fast_res;

   assign is_div_in = funct3[2];
   assign a_signed  = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                      (funct3 == OP_DIV)  || (funct3 == OP_REM);
   assign b_signed  = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
   assign sign_a    = a_signed & rs1_val[XLEN-1];
   assign sign_b    = b_signed & rs2_val[XLEN-1];
   assign abs_a     = sign_a ? (XLEN'(0) - rs1_val) : rs1_val;
   assign abs_b     = sign_b ? (XLEN'(0) - rs2_val) : rs2_val;
   // Remainder takes the dividend's sign; quotient and products the xor of both
   assign neg_in    = (is_div_in && funct3[1]) ? sign_a : (sign_a ^ sign_b);
   assign div_zero  = is_div_in && (rs2_val == '0);
   assign div_ovf   = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                      (rs1_val == MIN_INT) && (rs2_val == '1);
   assign fast_in   = div_zero || div_ovf;

   always_comb begin
      fast_res = '0;
      if (div_zero) begin
         fast_res = funct3[1] ? rs1_val : '1;
      end else begin
         fast_res = funct3[1] ? '0 : MIN_INT;
      end
   end

   // One multiply step: conditional add of the multiplicand, then shift right
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

   // One restoring divide step on the 33-bit shifted partial remainder
   logic [XLEN:0]   div_shift;
   logic [XLEN:0]   div_diff;
   logic            div_borrow;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;

   assign div_shift  = {rem_q, acc_q[XLEN-1]};
   assign div_diff   = div_shift - {1'b0, opnd_q};
   assign div_borrow = div_diff[XLEN];
   assign rem_next   = div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
   assign quo_next   = {acc_q[XLEN-2:0], ~div_borrow};

   // Sign fix-up of the value produced by the final step
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   div_pick, div_fix, final_res;

   assign prod_fix  = neg_q ? ((2*XLEN)'(0) - mul_next) : mul_next;
   assign div_pick  = op_q[1] ? rem_next : quo_next;
   assign div_fix   = neg_q ? (XLEN'(0) - div_pick) : div_pick;
   assign final_res = op_q[2] ? div_fix :
                      ((op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      result_d = result_q;
      rd_d     = rd_q;

      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               op_d  = funct3;
               rd_d  = rd_in;
               neg_d = neg_in;
               cnt_d = '0;
               rem_d = '0;
               if (is_div_in) begin
                  opnd_d = abs_b;
                  acc_d  = {XLEN'(0), abs_a};
               end else begin
                  opnd_d = abs_a;
                  acc_d  = {XLEN'(0), abs_b};
               end
               if (fast_in) begin
                  result_d = fast_res;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_RUN;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q[2]) begin
               acc_d = {acc_q[2*XLEN-1:XLEN], quo_next};
               rem_d = rem_next;
            end else begin
               acc_d = mul_next;
            end
            if (cnt_q == CNT_W'(XLEN-1)) begin
               result_d = final_res;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over accept and completion; a flushed op never touches result
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   assign busy      = (state_q == S_RUN);
   assign valid     = (state_q == S_DONE) && !flush;
   assign stall_req = start && !valid;
   assign result    = result_q;
   assign rd_out    = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: reference results from 64-bit host arithmetic,
// checked together with latency, stall, hold, flush and reset behaviour.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val;
   logic [4:0]  rd_in;
   logic        busy, valid, stall_req;
   logic [31:0] result;
   logic [4:0]  rd_out;

   always #5 clk = ~clk;

   ex_muldiv_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .funct3    (funct3),
      .rs1_val   (rs1_val),
      .rs2_val   (rs2_val),
      .rd_in     (rd_in),
      .flush     (flush),
      .busy      (busy),
      .valid     (valid),
      .result    (result),
      .rd_out    (rd_out),
      .stall_req (stall_req)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] prev_res;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      int          ia, ib;
      bit          ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ia  = a;
      ib  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Called at a falling edge. lead=1 when chained behind a held start (DUT still in DONE).
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lead, input bit hold);
      exp_t e, got;
      int   cyc, bad_stall, bad_res;
      bit   seen;
      e.res = model_res(f3, a, b);
      e.rd  = rd;
      e.lat = (is_fast(f3, a, b) ? 1 : 33) + lead;
      sb_q.push_back(e);
      funct3  = f3;
      rs1_val = a;
      rs2_val = b;
      rd_in   = rd;
      start   = 1'b1;
      if (lead == 0) begin
         #1;
         check_eq("stall_c0", 32'(stall_req), 32'd1);
      end
      cyc       = 0;
      bad_stall = 0;
      bad_res   = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (valid) break;
         if (stall_req !== 1'b1) bad_stall++;
         if (result !== prev_res) bad_res++;
         if (cyc == lead + 1) check_eq("busy_run", 32'(busy), 32'd1);
         if (cyc > 200) break;
      end
      seen = (valid === 1'b1);
      check_eq("latency", 32'(cyc), 32'(e.lat));
      check_eq("stall_hold", 32'(bad_stall), 32'd0);
      check_eq("res_hold", 32'(bad_res), 32'd0);
      got = sb_q.pop_front();
      if (seen) begin
         check_eq("stall_at_valid", 32'(stall_req), 32'd0);
         check_eq("result", result, got.res);
         check_eq("rd_out", 32'(rd_out), 32'(got.rd));
         prev_res = got.res;
      end
      $display("op f3=%0d a=%h b=%h rd=%0d -> result=%h rd_out=%0d lat=%0d (exp %h lat %0d)",
               f3, a, b, rd, result, rd_out, cyc, got.res, got.lat);
      if (!hold) begin
         start = 1'b0;
         @(negedge clk);
         check_eq("one_pulse", 32'(valid), 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;
      rst      = 1'b1;
      start    = 1'b0;
      flush    = 1'b0;
      funct3   = 3'd0;
      rs1_val  = 32'd0;
      rs2_val  = 32'd0;
      rd_in    = 5'd0;
      prev_res = 32'd0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_result", result, 32'd0);
      check_eq("rst_rd", 32'(rd_out), 32'd0);
      check_eq("rst_stall", 32'(stall_req), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  0, 0);
      do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  0, 0);
      do_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  0, 0);
      do_op(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd8,  0, 0);
      do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  0, 0);
      do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 0, 0);
      do_op(3'd5, 32'd100,        32'd7,         5'd11, 0, 0);
      do_op(3'd7, 32'd100,        32'd7,         5'd12, 0, 0);
      do_op(3'd5, 32'd5,          32'd0,         5'd13, 0, 0);
      do_op(3'd6, 32'd5,          32'd0,         5'd14, 0, 0);
      do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 0, 0);
      do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 0, 0);

      // start held high across valid: next op enters only after DONE->IDLE
      do_op(3'd0, 32'd3,          32'd4,         5'd1,  0, 1);
      do_op(3'd4, 32'd1000,       32'hFFFF_FFF9, 5'd2,  1, 1);
      do_op(3'd7, 32'd9,          32'd0,         5'd3,  1, 0);

      // flush at RUN cycle 10
      funct3  = 3'd0;
      rs1_val = 32'd123;
      rs2_val = 32'd456;
      rd_in   = 5'd20;
      start   = 1'b1;
      repeat (11) @(negedge clk);
      check_eq("flush_pre_busy", 32'(busy), 32'd1);
      flush = 1'b1;
      start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush_busy", 32'(busy), 32'd0);
      check_eq("flush_valid", 32'(valid), 32'd0);
      check_eq("flush_result", result, prev_res);
      nv = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) nv++;
      end
      check_eq("flush_novalid", 32'(nv), 32'd0);
      $display("flush op discarded, valid pulses afterwards=%0d", nv);
      do_op(3'd3, 32'd65536, 32'd65537, 5'd21, 0, 0);

      // reset in the middle of RUN
      funct3  = 3'd4;
      rs1_val = 32'd77;
      rs2_val = 32'd5;
      rd_in   = 5'd22;
      start   = 1'b1;
      repeat (15) @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_valid", 32'(valid), 32'd0);
      check_eq("mid_rst_result", result, 32'd0);
      check_eq("mid_rst_rd", 32'(rd_out), 32'd0);
      check_eq("mid_rst_stall", 32'(stall_req), 32'd0);
      $display("reset during RUN, outputs busy=%0d valid=%0d result=%h rd_out=%0d",
               busy, valid, result, rd_out);
      rst      = 1'b0;
      prev_res = 32'd0;
      @(negedge clk);
      do_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd23, 0, 0);

      for (int i = 0; i < 12; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         int          sel;
         f3  = 3'($urandom_range(0, 7));
         a   = $urandom;
         sel = $urandom_range(0, 5);
         if (sel == 0) begin
            b = 32'd0;
         end else if (sel == 1) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else begin
            b = $urandom;
         end
         do_op(f3, a, b, 5'($urandom_range(1, 31)), 0, 0);
      end

      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
